// File: rtl/sr_pkg.sv
// sr_pkg: conflict-resolution mode encodings shared by the SR register bank.
package sr_pkg;
    typedef logic [1:0] sr_mode_t;
    localparam sr_mode_t SR_MODE_HOLD   = 2'd0;
    localparam sr_mode_t SR_MODE_SET    = 2'd1;
    localparam sr_mode_t SR_MODE_RESET  = 2'd2;
    localparam sr_mode_t SR_MODE_TOGGLE = 2'd3;
endpackage

// File: rtl/sr_cell.sv
// sr_cell: one clocked SR channel with complementary outputs and a sticky s=r=1 flag.
module sr_cell
    import sr_pkg::*;
#(
    parameter logic INIT          = 1'b0,
    parameter int   CONFLICT_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic clr_flag,
    output logic q,
    output logic qbar,
    output logic conflict
);
    // Out-of-range modes fall back to HOLD.
    localparam sr_mode_t MODE = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 3) ?
                                sr_mode_t'(CONFLICT_MODE) : SR_MODE_HOLD;
    logic hit, res, d;
    always_comb begin
        hit = en & s & r;
        res = (MODE == SR_MODE_SET)    ? 1'b1 :
              (MODE == SR_MODE_RESET)  ? 1'b0 :
              (MODE == SR_MODE_TOGGLE) ? ~q   : q;
        d   = !en ? q : hit ? res : s ? 1'b1 : r ? 1'b0 : q;
    end
    // qbar has its own flop fed with ~d so both outputs update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= INIT;
            qbar     <= ~INIT;
            conflict <= 1'b0;
        end else begin
            q        <= d;
            qbar     <= ~d;
            conflict <= hit | (conflict & ~clr_flag);
        end
    end
endmodule

// File: rtl/sr_reg_bank.sv
// sr_reg_bank: WIDTH independent SR channels with shared enable and sticky conflict flags.
// Defining SR_REG_BANK_CONFLICT_CNT_EN adds a saturating conflict-cycle counter (conflict_cnt).
module sr_reg_bank #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}},
    parameter int               CONFLICT_MODE = 0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(.INIT(INIT[i]), .CONFLICT_MODE(CONFLICT_MODE)) u_cell (
            .clk(clk), .rst(rst), .en(en), .s(s[i]), .r(r[i]), .clr_flag(clr_flag),
            .q(q[i]), .qbar(qbar[i]), .conflict(conflict[i])
        );
    end
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    logic any_hit;
    always_comb any_hit = en & |(s & r);
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (clr_flag)
            conflict_cnt <= CNT_W'(any_hit);
        else if (any_hit && conflict_cnt != {CNT_W{1'b1}})
            conflict_cnt <= conflict_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_sr_reg_bank.sv
// tb_sr_reg_bank: directed steps on four banks (one per conflict mode) checked against a queued reference model.
module tb_sr_reg_bank;
    import sr_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst = 1'b1, en = 1'b0, clr_flag = 1'b0;
    logic [3:0] s = 4'h0, r = 4'h0;
    logic [3:0] q [4];
    logic [3:0] qbar [4];
    logic [3:0] conflict [4];
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    logic [1:0] cnt [4];
`endif
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_reg_bank #(.WIDTH(4), .INIT(4'b0101), .CONFLICT_MODE(g), .CNT_W(2)) u_dut (
            .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
            .q(q[g]), .qbar(qbar[g]), .conflict(conflict[g])
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
            , .conflict_cnt(cnt[g])
`endif
        );
    end
    typedef struct {
        string      tag;
        logic [3:0] q [4];
        logic [3:0] c;
        logic [1:0] cnt;
    } exp_t;
    exp_t       sb [$];
    logic [3:0] m_q [4];
    logic [3:0] m_c = 4'h0;
    logic [1:0] m_cnt = 2'd0;
    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(string tag, logic rr, logic ee, logic [3:0] ss, logic [3:0] rs, logic cc);
        logic [3:0] hit;
        exp_t e, o;
        @(negedge clk);
        rst = rr; en = ee; s = ss; r = rs; clr_flag = cc;
        hit = ee ? (ss & rs) : 4'h0;
        if (rr) begin
            for (int m = 0; m < 4; m++) m_q[m] = 4'b0101;
            m_c = 4'h0;
            m_cnt = 2'd0;
        end else begin
            for (int m = 0; m < 4; m++)
                for (int b = 0; b < 4; b++)
                    if (ee && ss[b] && rs[b]) begin
                        case (m)
                            1: m_q[m][b] = 1'b1;
                            2: m_q[m][b] = 1'b0;
                            3: m_q[m][b] = ~m_q[m][b];
                            default: ;
                        endcase
                    end else if (ee && ss[b]) m_q[m][b] = 1'b1;
                    else if (ee && rs[b]) m_q[m][b] = 1'b0;
            m_c = cc ? hit : (m_c | hit);
            if (cc) m_cnt = (hit != 0) ? 2'd1 : 2'd0;
            else if (hit != 0 && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
        e.tag = tag; e.q = m_q; e.c = m_c; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s m%0d q", o.tag, m), q[m], o.q[m]);
            chk($sformatf("%s m%0d qbar", o.tag, m), qbar[m], ~o.q[m]);
            chk($sformatf("%s m%0d conflict", o.tag, m), conflict[m], o.c);
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
            chk($sformatf("%s m%0d cnt", o.tag, m), {2'b00, cnt[m]}, {2'b00, o.cnt});
`endif
        end
    endtask

    initial begin
        step("reset",     1, 1, 4'hF, 4'h0, 0);
        chk("reset q const", q[0], 4'b0101);
        step("set0011",   0, 1, 4'h3, 4'h0, 0);
        chk("set q const", q[0], 4'b0111);
        step("rst0110",   0, 1, 4'h0, 4'h6, 0);
        step("idle",      0, 1, 4'h0, 4'h0, 0);
        chk("idle q const", q[0], 4'b0001);
        step("en_off",    0, 0, 4'hF, 4'h0, 0);
        step("en_off_sr", 0, 0, 4'hF, 4'hF, 0);
        step("load0101",  0, 1, 4'h5, 4'hA, 0);
        step("conf_all",  0, 1, 4'hF, 4'hF, 0);
        chk("toggle q const", q[3], 4'b1010);
        chk("conf_all const", conflict[0], 4'b1111);
        step("reset2",    1, 0, 4'h0, 4'h0, 0);
        step("conf_ch2",  0, 1, 4'h4, 4'h4, 0);
        chk("ch2 flag const", conflict[1], 4'b0100);
        for (int i = 0; i < 3; i++) step("sticky", 0, 1, 4'h0, 4'h0, 0);
        step("clr",       0, 1, 4'h0, 4'h0, 1);
        step("clr_conf0", 0, 1, 4'h1, 4'h1, 1);
        chk("clr_conf0 const", conflict[2], 4'b0001);
        step("reset3",    1, 1, 4'h0, 4'h0, 0);
        step("cnt1",      0, 1, 4'h1, 4'h1, 0);
        step("cnt2",      0, 1, 4'h3, 4'h3, 0);
        step("cnt3",      0, 1, 4'h7, 4'h7, 0);
        step("cnt_sat1",  0, 1, 4'hF, 4'hF, 0);
        step("cnt_sat2",  0, 1, 4'hF, 4'hF, 0);
        step("cnt_clr",   0, 1, 4'h2, 4'h2, 1);
        step("cnt_idle",  0, 1, 4'h0, 4'h0, 0);
        step("rst_conf",  1, 1, 4'hF, 4'hF, 1);
        chk("rst_conf q const", q[1], 4'b0101);
        step("after_rst", 0, 1, 4'h8, 4'h1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
